// File: rtl/camera_init_sequencer.sv
// -----------------------------------------------------------------------------
// camera_init_sequencer
//
// Powers up an image sensor and walks a register table, issuing each entry as
// a write command to an SCCB master. The sequence runs after a start pulse.
// It holds the sensor in reset, waits for power-up, then fetches entries from
// a synchronous ROM. Table entries are decoded as follows:
//   16'hFFFF  end of table
//   16'hFEnn  wait nn*DELAY_UNIT cycles (nn = 0: no wait)
//   other     write val[7:0] to reg[15:8]
// A NACKed write is retried up to MAX_RETRY extra times before the block
// reports an error.
//
// Optional feature (macro CAM_INIT_READBACK_EN):
//   Each ACKed write is followed by a read of the same register. A NACK or a
//   value mismatch consumes one retry and re-issues the write.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   start                 1-cycle pulse, (re)starts the sequence when not busy
//   busy                  high outside IDLE / DONE / ERROR
//   init_done, init_error final status
//   err_index             table index of the failing entry (valid with init_error)
//   cam_reset             sensor reset pin (0 = sensor held in reset)
//   tbl_addr, tbl_data    table ROM read port (1-cycle latency)
//   sccb_valid/ready      command handshake to the SCCB master
//   sccb_rw/dev/reg/wdata command fields
//   sccb_done/nack/rdata  command completion from the SCCB master
// -----------------------------------------------------------------------------
module camera_init_sequencer #(
    parameter int unsigned TBL_AW       = 8,
    parameter logic [7:0]  DEV_ADDR     = 8'h42,
    parameter int unsigned RST_CYCLES   = 1000,
    parameter int unsigned PWRUP_CYCLES = 100000,
    parameter int unsigned DELAY_UNIT   = 50000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              init_done,
    output logic              init_error,
    output logic [TBL_AW-1:0] err_index,
    output logic              cam_reset,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              sccb_valid,
    input  logic              sccb_ready,
    output logic              sccb_rw,
    output logic [7:0]        sccb_dev,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_wdata,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    input  logic [7:0]        sccb_rdata
);

    localparam int unsigned PWR_MAX = (RST_CYCLES > PWRUP_CYCLES) ? RST_CYCLES : PWRUP_CYCLES;
    localparam int unsigned PWR_W   = $clog2(PWR_MAX + 1);
    localparam int unsigned DLY_W   = $clog2(255 * DELAY_UNIT + 1);
    localparam int unsigned RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_ASSERT,
        S_RST_WAIT,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT_RESP,
        S_DELAY,
        S_DONE,
        S_ERROR
`ifdef CAM_INIT_READBACK_EN
        ,
        S_RB_ISSUE,
        S_RB_WAIT
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [PWR_W-1:0]   pwr_cnt_q, pwr_cnt_d;
    logic [DLY_W-1:0]   dly_cnt_q, dly_cnt_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [TBL_AW-1:0]  addr_q, addr_d;
    logic [TBL_AW-1:0]  err_idx_q, err_idx_d;
    logic [7:0]         reg_q, reg_d;
    logic [7:0]         val_q, val_d;

    // Shared actions requested by several states, resolved once below.
    logic advance;       // move to the next table entry
    logic retry_or_fail; // current write failed: retry it or give up

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state_q   <= S_IDLE;
            pwr_cnt_q <= '0;
            dly_cnt_q <= '0;
            retry_q   <= '0;
            addr_q    <= '0;
            err_idx_q <= '0;
            reg_q     <= '0;
            val_q     <= '0;
        end else begin
            state_q   <= state_d;
            pwr_cnt_q <= pwr_cnt_d;
            dly_cnt_q <= dly_cnt_d;
            retry_q   <= retry_d;
            addr_q    <= addr_d;
            err_idx_q <= err_idx_d;
            reg_q     <= reg_d;
            val_q     <= val_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold value first so no path through the
        // case statement leaves it unassigned (which would infer a latch).
        state_d       = state_q;
        pwr_cnt_d     = pwr_cnt_q;
        dly_cnt_d     = dly_cnt_q;
        retry_d       = retry_q;
        addr_d        = addr_q;
        err_idx_d     = err_idx_q;
        reg_d         = reg_q;
        val_d         = val_q;
        advance       = 1'b0;
        retry_or_fail = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pwr_cnt_d = '0;
                    state_d   = S_RST_ASSERT;
                end
            end
            S_RST_ASSERT: begin
                if (pwr_cnt_q == PWR_W'(RST_CYCLES - 1)) begin
                    pwr_cnt_d = '0;
                    state_d   = S_RST_WAIT;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            S_RST_WAIT: begin
                if (pwr_cnt_q == PWR_W'(PWRUP_CYCLES - 1)) begin
                    pwr_cnt_d = '0;
                    addr_d    = '0;
                    state_d   = S_FETCH;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end
            end
            S_FETCH: state_d = S_DECODE;  // ROM data is valid one cycle later
            S_DECODE: begin
                if (tbl_data == 16'hFFFF) begin
                    state_d = S_DONE;
                end else if (tbl_data[15:8] == 8'hFE) begin
                    // A zero delay skips the DELAY state entirely.
                    if (tbl_data[7:0] == 8'd0) begin
                        advance = 1'b1;
                    end else begin
                        dly_cnt_d = DLY_W'(tbl_data[7:0]) * DLY_W'(DELAY_UNIT);
                        state_d   = S_DELAY;
                    end
                end else begin
                    reg_d   = tbl_data[15:8];
                    val_d   = tbl_data[7:0];
                    retry_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (sccb_ready) state_d = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                if (sccb_done) begin
                    if (!sccb_nack) begin
`ifdef CAM_INIT_READBACK_EN
                        state_d = S_RB_ISSUE;
`else
                        advance = 1'b1;
`endif
                    end else begin
                        retry_or_fail = 1'b1;
                    end
                end
            end
            S_DELAY: begin
                // Loaded with N, leaves after exactly N cycles in this state.
                if (dly_cnt_q == DLY_W'(1)) begin
                    dly_cnt_d = '0;
                    advance   = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q - 1'b1;
                end
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    pwr_cnt_d = '0;
                    err_idx_d = '0;
                    state_d   = S_RST_ASSERT;
                end
            end
`ifdef CAM_INIT_READBACK_EN
            S_RB_ISSUE: begin
                if (sccb_ready) state_d = S_RB_WAIT;
            end
            S_RB_WAIT: begin
                if (sccb_done) begin
                    if (!sccb_nack && sccb_rdata == val_q) advance = 1'b1;
                    else retry_or_fail = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (retry_or_fail) begin
            if (retry_q < RTY_W'(MAX_RETRY)) begin
                retry_d = retry_q + 1'b1;
                state_d = S_ISSUE;
            end else begin
                err_idx_d = addr_q;
                state_d   = S_ERROR;
            end
        end

        // Running off the end of the table without an end entry is an error.
        if (advance) begin
            if (addr_q == '1) begin
                err_idx_d = '1;
                state_d   = S_ERROR;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
            end
        end
    end

    assign busy       = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
    assign init_done  = (state_q == S_DONE);
    assign init_error = (state_q == S_ERROR);
    assign err_index  = err_idx_q;
    assign cam_reset  = (state_q != S_RST_ASSERT);
    assign tbl_addr   = addr_q;
    assign sccb_dev   = DEV_ADDR;
    assign sccb_reg   = reg_q;

`ifdef CAM_INIT_READBACK_EN
    logic rb_phase;
    assign rb_phase   = (state_q == S_RB_ISSUE) || (state_q == S_RB_WAIT);
    assign sccb_valid = (state_q == S_ISSUE) || (state_q == S_RB_ISSUE);
    assign sccb_rw    = rb_phase;
    assign sccb_wdata = rb_phase ? 8'h00 : val_q;
`else
    // Read data is only consumed by the readback option.
    logic unused_rdata;
    assign unused_rdata = ^sccb_rdata;
    assign sccb_valid   = (state_q == S_ISSUE);
    assign sccb_rw      = 1'b0;
    assign sccb_wdata   = val_q;
`endif

endmodule

// File: tb/tb_camera_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_camera_init_sequencer
//
// Bench for camera_init_sequencer with small timing parameters. A ROM model
// and an SCCB master responder drive the DUT. A reference model derives the
// expected command stream, the first-command latency and the final status
// directly from the table and the per-entry NACK plan.
// -----------------------------------------------------------------------------
module tb_camera_init_sequencer;

    localparam int          TBL_AW       = 4;
    localparam int          TBL_N        = 1 << TBL_AW;
    localparam int          RST_CYCLES   = 10;
    localparam int          PWRUP_CYCLES = 20;
    localparam int          DELAY_UNIT   = 5;
    localparam int          MAX_RETRY    = 3;
    localparam logic [7:0]  DEV_ADDR     = 8'h42;
    localparam int          BUDGET       = 3000;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy, init_done, init_error, cam_reset;
    logic [TBL_AW-1:0] err_index, tbl_addr;
    logic [15:0]       tbl_data;
    logic              sccb_valid, sccb_ready, sccb_rw;
    logic [7:0]        sccb_dev, sccb_reg, sccb_wdata;
    logic              sccb_done, sccb_nack;
    logic [7:0]        sccb_rdata;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    camera_init_sequencer #(
        .TBL_AW      (TBL_AW),
        .DEV_ADDR    (DEV_ADDR),
        .RST_CYCLES  (RST_CYCLES),
        .PWRUP_CYCLES(PWRUP_CYCLES),
        .DELAY_UNIT  (DELAY_UNIT),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .init_done (init_done),
        .init_error(init_error),
        .err_index (err_index),
        .cam_reset (cam_reset),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .sccb_valid(sccb_valid),
        .sccb_ready(sccb_ready),
        .sccb_rw   (sccb_rw),
        .sccb_dev  (sccb_dev),
        .sccb_reg  (sccb_reg),
        .sccb_wdata(sccb_wdata),
        .sccb_done (sccb_done),
        .sccb_nack (sccb_nack),
        .sccb_rdata(sccb_rdata)
    );

    // ---------------- table ROM (1-cycle latency) and NACK plan --------------
    logic [15:0] rom   [TBL_N];
    int          nacks [TBL_N];   // NACKs before the first ACK, per entry

    always @(posedge clk) tbl_data <= rom[tbl_addr];

    task automatic clear_table();
        for (int i = 0; i < TBL_N; i++) begin
            rom[i]   = 16'hFFFF;
            nacks[i] = 0;
        end
    endtask

    // ---------------- reference model ----------------------------------------
    logic [15:0]       exp_cmds[$];
    bit                nack_seq[$];
    int                exp_lat;
    bit                exp_err;
    bit                exp_has_write;
    logic [TBL_AW-1:0] exp_idx;

    function automatic void build_model();
        logic [15:0] e;
        int attempts;
        exp_cmds.delete();
        nack_seq.delete();
        exp_lat       = PWRUP_CYCLES;
        exp_err       = 1'b0;
        exp_idx       = '0;
        exp_has_write = 1'b0;
        for (int i = 0; ; i++) begin
            if (i == TBL_N) begin
                exp_err = 1'b1;
                exp_idx = '1;
                break;
            end
            e = rom[i];
            if (!exp_has_write) exp_lat += 2;   // fetch + decode of this entry
            if (e == 16'hFFFF) break;
            if (e[15:8] == 8'hFE) begin
                if (!exp_has_write) exp_lat += int'(e[7:0]) * DELAY_UNIT;
                continue;
            end
            exp_has_write = 1'b1;
            attempts = (nacks[i] > MAX_RETRY) ? MAX_RETRY + 1 : nacks[i] + 1;
            for (int a = 0; a < attempts; a++) begin
                exp_cmds.push_back(e);
                nack_seq.push_back(a < nacks[i]);
            end
            if (nacks[i] > MAX_RETRY) begin
                exp_err = 1'b1;
                exp_idx = TBL_AW'(i);
                break;
            end
        end
    endfunction

    // ---------------- SCCB master responder ----------------------------------
    int ready_dly = 0;
    int resp_dly  = 0;
    bit stray_en  = 1'b0;   // inject done pulses while no command is pending

    initial begin : responder
        int phase;
        int cnt;
        phase = 0;
        cnt   = 0;
        sccb_ready = 1'b0;
        sccb_done  = 1'b0;
        sccb_nack  = 1'b0;
        sccb_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            sccb_done = 1'b0;
            sccb_nack = 1'b0;
            if (!reset) begin
                phase      = 0;
                sccb_ready = 1'b0;
            end else begin
                case (phase)
                    0: begin
                        if (sccb_valid) begin
                            if (ready_dly == 0) begin
                                sccb_ready = 1'b1;
                                phase      = 2;
                            end else begin
                                cnt   = ready_dly;
                                phase = 1;
                            end
                        end else if (stray_en && $urandom_range(0, 3) == 0) begin
                            sccb_done = 1'b1;
                            sccb_nack = 1'($urandom_range(0, 1));
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            sccb_ready = 1'b1;
                            phase      = 2;
                        end
                    end
                    2: begin   // transfer happened on the edge just passed
                        sccb_ready = 1'b0;
                        cnt        = resp_dly;
                        phase      = 3;
                    end
                    3: begin
                        if (cnt == 0) begin
                            sccb_done = 1'b1;
                            sccb_nack = (nack_seq.size() > 0) ? nack_seq.pop_front() : 1'b0;
                            phase     = 0;
                        end else begin
                            cnt--;
                        end
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    // ---------------- command monitor ----------------------------------------
    logic [15:0] cap_cmds[$];
    int          stab_viol = 0;
    int          bad_field = 0;
    bit          pend      = 1'b0;
    logic [15:0] pend_cmd;

    always @(negedge clk) begin
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pend && (!sccb_valid || {sccb_reg, sccb_wdata} != pend_cmd)) stab_viol++;
            if (sccb_valid) begin
                if (sccb_rw !== 1'b0 || sccb_dev !== DEV_ADDR) bad_field++;
                if (sccb_ready) begin
                    cap_cmds.push_back({sccb_reg, sccb_wdata});
                    pend = 1'b0;
                end else begin
                    pend     = 1'b1;
                    pend_cmd = {sccb_reg, sccb_wdata};
                end
            end else begin
                pend = 1'b0;
            end
        end
    end

    // ---------------- one full init run against the model --------------------
    task automatic run_seq(input string name, input bit poke);
        int cyc, low, lat, since_rel, n;
        bit poked, timed_out;
        build_model();
        cap_cmds.delete();
        stab_viol = 0;
        bad_field = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (init_done !== 1'b0 || init_error !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s start_clears: done=%b error=%b busy=%b, want 0 0 1",
                     name, init_done, init_error, busy);
        end
        low = 0; lat = -1; since_rel = 0; cyc = 0; poked = 0; timed_out = 0;
        forever begin
            if (!cam_reset) low++;
            else if (low > 0 && lat < 0) begin
                if (sccb_valid) lat = since_rel;
                else since_rel++;
            end
            if (init_done || init_error) break;
            if (cyc >= BUDGET) begin
                timed_out = 1'b1;
                break;
            end
            // start pulse while busy (power-up wait) must be ignored
            if (poke && !poked && low > 0 && cam_reset) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        vectors++;
        if (timed_out) begin
            miscompares++;
            $display("FAIL %s timeout: no done/error within %0d cycles", name, BUDGET);
        end
        vectors++;
        if (low != RST_CYCLES) begin
            miscompares++;
            $display("FAIL %s cam_reset_low: got %0d cycles, want %0d", name, low, RST_CYCLES);
        end
        if (exp_has_write) begin
            vectors++;
            if (lat != exp_lat) begin
                miscompares++;
                $display("FAIL %s first_valid_latency: got %0d, want %0d", name, lat, exp_lat);
            end
        end
        vectors++;
        if (init_done !== !exp_err || init_error !== exp_err || busy !== 1'b0 || sccb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s status: done=%b error=%b busy=%b valid=%b, want %b %b 0 0",
                     name, init_done, init_error, busy, sccb_valid, !exp_err, exp_err);
        end
        if (exp_err) begin
            vectors++;
            if (err_index !== exp_idx) begin
                miscompares++;
                $display("FAIL %s err_index: got %0d, want %0d", name, err_index, exp_idx);
            end
        end
        vectors++;
        if (cap_cmds.size() != exp_cmds.size()) begin
            miscompares++;
            $display("FAIL %s cmd_count: got %0d, want %0d", name, cap_cmds.size(), exp_cmds.size());
        end
        n = (cap_cmds.size() < exp_cmds.size()) ? cap_cmds.size() : exp_cmds.size();
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (cap_cmds[i] !== exp_cmds[i]) begin
                miscompares++;
                $display("FAIL %s cmd[%0d]: got reg/val %h, want %h", name, i, cap_cmds[i], exp_cmds[i]);
            end
        end
        vectors++;
        if (stab_viol != 0 || bad_field != 0) begin
            miscompares++;
            $display("FAIL %s cmd_fields: %0d unstable cycles, %0d bad rw/dev, want 0 0",
                     name, stab_viol, bad_field);
        end
    endtask

    // ---------------- scenarios ----------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        clear_table();
        #12;
        vectors++;
        if ({busy, init_done, init_error, err_index, cam_reset, tbl_addr, sccb_valid, sccb_rw, sccb_reg, sccb_wdata}
            !== {1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b done=%b err=%b idx=%h cam_reset=%b addr=%h valid=%b rw=%b reg=%h wdata=%h",
                     busy, init_done, init_error, err_index, cam_reset, tbl_addr, sccb_valid, sccb_rw, sccb_reg, sccb_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || cam_reset !== 1'b1 || init_done !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_without_start: busy=%b cam_reset=%b done=%b, want 0 1 0",
                     busy, cam_reset, init_done);
        end
    endtask

    task automatic test_basic_writes();
        clear_table();
        rom[0] = 16'h1280;
        rom[1] = 16'h1204;
        ready_dly = 3;
        resp_dly  = 2;
        stray_en  = 1'b0;
        run_seq("basic_writes", 1'b0);
    endtask

    task automatic test_back_to_back();
        ready_dly = 0;
        resp_dly  = 0;
        run_seq("restart_from_done", 1'b0);
        run_seq("start_while_busy", 1'b1);
    endtask

    task automatic test_delay();
        clear_table();
        rom[0] = 16'hFE02;
        rom[1] = 16'h1180;
        ready_dly = 1;
        resp_dly  = 1;
        stray_en  = 1'b1;
        run_seq("delay_fe02", 1'b0);
        rom[0] = 16'hFE00;
        run_seq("delay_fe00", 1'b0);
        stray_en = 1'b0;
    endtask

    task automatic test_nack_error();
        clear_table();
        rom[0]   = 16'h1280;
        rom[1]   = 16'h1311;
        rom[2]   = 16'h1422;
        nacks[1] = 4;
        ready_dly = 1;
        resp_dly  = 1;
        run_seq("nack_exhaust", 1'b0);
    endtask

    task automatic test_nack_once();
        clear_table();
        rom[0]   = 16'h3A5C;
        nacks[0] = 1;
        run_seq("nack_once", 1'b0);
    endtask

    task automatic test_wrap();
        clear_table();
        for (int i = 0; i < TBL_N; i++) rom[i] = {8'h20 + 8'(i), 8'(i * 7)};
        ready_dly = 0;
        resp_dly  = 0;
        run_seq("table_wrap", 1'b0);
    endtask

    task automatic test_reset_mid();
        int cyc;
        clear_table();
        rom[0] = 16'h2233;
        rom[1] = 16'h2455;
        ready_dly = 1;
        resp_dly  = 6;
        build_model();
        cap_cmds.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cap_cmds.size() == 0 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cap_cmds.size() == 0) begin
            miscompares++;
            $display("FAIL mid_reset_handshake: no command within %0d cycles", BUDGET);
        end
        @(posedge clk);
        #3;
        vectors++;
        if (busy !== 1'b1 || sccb_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_waiting: busy=%b valid=%b, want 1 0", busy, sccb_valid);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({busy, init_done, init_error, err_index, cam_reset, tbl_addr, sccb_valid, sccb_rw, sccb_reg, sccb_wdata}
            !== {1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            miscompares++;
            $display("FAIL mid_reset_values: busy=%b done=%b err=%b idx=%h cam_reset=%b addr=%h valid=%b rw=%b reg=%h wdata=%h",
                     busy, init_done, init_error, err_index, cam_reset, tbl_addr, sccb_valid, sccb_rw, sccb_reg, sccb_wdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        resp_dly = 2;
        run_seq("after_mid_reset", 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] r;
        int n;
        for (int it = 0; it < 8; it++) begin
            clear_table();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    rom[i] = {8'hFE, 8'($urandom_range(0, 2))};
                end else begin
                    r = 16'($urandom);
                    if (r[15:8] == 8'hFE || r == 16'hFFFF) r[15:8] = 8'h01;
                    rom[i] = r;
                end
                nacks[i] = ($urandom_range(0, 5) == 0) ? 4 : $urandom_range(0, 2);
            end
            ready_dly = $urandom_range(0, 3);
            resp_dly  = $urandom_range(0, 3);
            stray_en  = 1'b1;
            run_seq($sformatf("random%0d", it), it[0]);
        end
        stray_en = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_writes();
        test_back_to_back();
        test_delay();
        test_nack_error();
        test_nack_once();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
